// File: rtl/spi_delay_capture.sv
// Deserializes frames from the variable-delay stage and measures the delay
// between the undelayed and delayed chip-select rising edges in clk cycles.
module spi_delay_capture #(
  parameter int W     = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ref_cs,
  input  logic             dly_cs,
  input  logic             dly_clk,
  input  logic             dly_data,
  output logic [W-1:0]     frame_data,
  output logic [CNT_W-1:0] frame_bits,
  output logic             frame_ovf,
  output logic             frame_valid,
  output logic [CNT_W-1:0] meas_delay,
  output logic             meas_timeout,
  output logic             meas_valid
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] W_CNT   = CNT_W'(W);

  typedef enum logic {
    F_IDLE   = 1'b0,
    F_ACTIVE = 1'b1
  } frame_state_e;

  typedef enum logic {
    D_IDLE = 1'b0,
    D_MEAS = 1'b1
  } dly_state_e;

  // Previous-cycle samples for edge detection
  logic ref_cs_q,  ref_cs_d;
  logic dly_cs_q,  dly_cs_d;
  logic dly_clk_q, dly_clk_d;

  logic ref_rise;
  logic cs_rise;
  logic cs_fall;
  logic clk_rise;

  frame_state_e     frame_state_q, frame_state_d;
  logic [W-1:0]     shift_q,       shift_d;
  logic [CNT_W-1:0] bit_cnt_q,     bit_cnt_d;
  logic [W-1:0]     frame_data_q,  frame_data_d;
  logic [CNT_W-1:0] frame_bits_q,  frame_bits_d;
  logic             frame_ovf_q,   frame_ovf_d;
  logic             frame_valid_q, frame_valid_d;

  dly_state_e       dly_state_q,    dly_state_d;
  logic [CNT_W-1:0] dcnt_q,         dcnt_d;
  logic [CNT_W-1:0] dcnt_next;
  logic [CNT_W-1:0] meas_delay_q,   meas_delay_d;
  logic             meas_timeout_q, meas_timeout_d;
  logic             meas_valid_q,   meas_valid_d;

  always_comb begin
    ref_cs_d  = ref_cs;
    dly_cs_d  = dly_cs;
    dly_clk_d = dly_clk;
    ref_rise  = ref_cs  & ~ref_cs_q;
    cs_rise   = dly_cs  & ~dly_cs_q;
    cs_fall   = ~dly_cs &  dly_cs_q;
    clk_rise  = dly_clk & ~dly_clk_q;
  end

  // Frame FSM: a dly_clk rise on the opening edge is already bit 1, while
  // one on the closing edge is dropped.
  always_comb begin
    frame_state_d = frame_state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    frame_data_d  = frame_data_q;
    frame_bits_d  = frame_bits_q;
    frame_ovf_d   = frame_ovf_q;
    frame_valid_d = 1'b0;
    case (frame_state_q)
      F_IDLE: begin
        if (cs_rise) begin
          frame_state_d = F_ACTIVE;
          if (clk_rise) begin
            shift_d   = {{(W-1){1'b0}}, dly_data};
            bit_cnt_d = CNT_ONE;
          end else begin
            shift_d   = '0;
            bit_cnt_d = '0;
          end
        end
      end
      F_ACTIVE: begin
        if (cs_fall) begin
          frame_state_d = F_IDLE;
          frame_data_d  = shift_q;
          frame_bits_d  = bit_cnt_q;
          frame_ovf_d   = (bit_cnt_q > W_CNT);
          frame_valid_d = 1'b1;
        end else if (clk_rise) begin
          shift_d = {shift_q[W-2:0], dly_data};
          if (bit_cnt_q != CNT_MAX) begin
            bit_cnt_d = bit_cnt_q + CNT_ONE;
          end
        end
      end
      default: frame_state_d = F_IDLE;
    endcase
  end

  // Delay FSM: dcnt_next is the number of edges since the ref_cs rise,
  // counting the current one.
  always_comb begin
    dly_state_d    = dly_state_q;
    dcnt_d         = dcnt_q;
    dcnt_next      = dcnt_q + CNT_ONE;
    meas_delay_d   = meas_delay_q;
    meas_timeout_d = meas_timeout_q;
    meas_valid_d   = 1'b0;
    case (dly_state_q)
      D_IDLE: begin
        if (ref_rise && cs_rise) begin
          meas_delay_d   = '0;
          meas_timeout_d = 1'b0;
          meas_valid_d   = 1'b1;
        end else if (ref_rise) begin
          dly_state_d = D_MEAS;
          dcnt_d      = '0;
        end
      end
      D_MEAS: begin
        if (cs_rise) begin
          dly_state_d    = D_IDLE;
          meas_delay_d   = dcnt_next;
          meas_timeout_d = 1'b0;
          meas_valid_d   = 1'b1;
        end else if (dcnt_next == CNT_MAX) begin
          dly_state_d    = D_IDLE;
          meas_delay_d   = CNT_MAX;
          meas_timeout_d = 1'b1;
          meas_valid_d   = 1'b1;
        end else begin
          dcnt_d = dcnt_next;
        end
      end
      default: dly_state_d = D_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cs_q       <= 1'b0;
      dly_cs_q       <= 1'b0;
      dly_clk_q      <= 1'b0;
      frame_state_q  <= F_IDLE;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      frame_data_q   <= '0;
      frame_bits_q   <= '0;
      frame_ovf_q    <= 1'b0;
      frame_valid_q  <= 1'b0;
      dly_state_q    <= D_IDLE;
      dcnt_q         <= '0;
      meas_delay_q   <= '0;
      meas_timeout_q <= 1'b0;
      meas_valid_q   <= 1'b0;
    end else begin
      ref_cs_q       <= ref_cs_d;
      dly_cs_q       <= dly_cs_d;
      dly_clk_q      <= dly_clk_d;
      frame_state_q  <= frame_state_d;
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      frame_data_q   <= frame_data_d;
      frame_bits_q   <= frame_bits_d;
      frame_ovf_q    <= frame_ovf_d;
      frame_valid_q  <= frame_valid_d;
      dly_state_q    <= dly_state_d;
      dcnt_q         <= dcnt_d;
      meas_delay_q   <= meas_delay_d;
      meas_timeout_q <= meas_timeout_d;
      meas_valid_q   <= meas_valid_d;
    end
  end

  assign frame_data   = frame_data_q;
  assign frame_bits   = frame_bits_q;
  assign frame_ovf    = frame_ovf_q;
  assign frame_valid  = frame_valid_q;
  assign meas_delay   = meas_delay_q;
  assign meas_timeout = meas_timeout_q;
  assign meas_valid   = meas_valid_q;

endmodule

// File: tb/tb_spi_delay_capture.sv
// Directed and randomized bench for spi_delay_capture; expected frames and
// delays are derived from the sent bit list and the driven chip-select gap.
module tb_spi_delay_capture;

  localparam int W     = 16;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ref_cs = 1'b0;
  logic             dly_cs = 1'b0;
  logic             dly_clk = 1'b0;
  logic             dly_data = 1'b0;
  logic [W-1:0]     frame_data;
  logic [CNT_W-1:0] frame_bits;
  logic             frame_ovf;
  logic             frame_valid;
  logic [CNT_W-1:0] meas_delay;
  logic             meas_timeout;
  logic             meas_valid;

  int checks = 0;
  int errors = 0;

  // Records are {ovf, bits, data} and {timeout, delay}
  logic [W+CNT_W:0] exp_f_q[$];
  logic [W+CNT_W:0] act_f_q[$];
  logic [CNT_W:0]   exp_m_q[$];
  logic [CNT_W:0]   act_m_q[$];

  spi_delay_capture #(.W(W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .ref_cs       (ref_cs),
    .dly_cs       (dly_cs),
    .dly_clk      (dly_clk),
    .dly_data     (dly_data),
    .frame_data   (frame_data),
    .frame_bits   (frame_bits),
    .frame_ovf    (frame_ovf),
    .frame_valid  (frame_valid),
    .meas_delay   (meas_delay),
    .meas_timeout (meas_timeout),
    .meas_valid   (meas_valid)
  );

  // Clock / reset block: reset is driven from the main sequence
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid) act_f_q.push_back({frame_ovf, frame_bits, frame_data});
    if (meas_valid)  act_m_q.push_back({meas_timeout, meas_delay});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_frame_data"},   32'(frame_data),   32'd0);
    chk({tag, "_frame_bits"},   32'(frame_bits),   32'd0);
    chk({tag, "_frame_ovf"},    32'(frame_ovf),    32'd0);
    chk({tag, "_frame_valid"},  32'(frame_valid),  32'd0);
    chk({tag, "_meas_delay"},   32'(meas_delay),   32'd0);
    chk({tag, "_meas_timeout"}, 32'(meas_timeout), 32'd0);
    chk({tag, "_meas_valid"},   32'(meas_valid),   32'd0);
  endtask

  // Scoreboard: pulse counts must match, then each record in order
  task automatic check_queues(input string tag);
    logic [W+CNT_W:0] ef, af;
    logic [CNT_W:0]   em, am;
    repeat (4) @(negedge clk);
    chk({tag, "_frame_count"}, 32'(act_f_q.size()), 32'(exp_f_q.size()));
    while (exp_f_q.size() > 0 && act_f_q.size() > 0) begin
      ef = exp_f_q.pop_front();
      af = act_f_q.pop_front();
      chk({tag, "_frame_data"}, 32'(af[W-1:0]),       32'(ef[W-1:0]));
      chk({tag, "_frame_bits"}, 32'(af[W+CNT_W-1:W]), 32'(ef[W+CNT_W-1:W]));
      chk({tag, "_frame_ovf"},  32'(af[W+CNT_W]),     32'(ef[W+CNT_W]));
    end
    chk({tag, "_meas_count"}, 32'(act_m_q.size()), 32'(exp_m_q.size()));
    while (exp_m_q.size() > 0 && act_m_q.size() > 0) begin
      em = exp_m_q.pop_front();
      am = act_m_q.pop_front();
      chk({tag, "_meas_delay"},   32'(am[CNT_W-1:0]), 32'(em[CNT_W-1:0]));
      chk({tag, "_meas_timeout"}, 32'(am[CNT_W]),     32'(em[CNT_W]));
    end
    exp_f_q.delete();
    act_f_q.delete();
    exp_m_q.delete();
    act_m_q.delete();
  endtask

  // Expected frame = count of bits sent (saturating) and the last W of them
  task automatic expect_frame(input bit sent_q[$]);
    int               n;
    logic [W-1:0]     data;
    logic [CNT_W-1:0] bits;
    n    = sent_q.size();
    data = '0;
    for (int k = 0; k < W && k < n; k++) data[k] = sent_q[n-1-k];
    bits = (n > 255) ? 8'd255 : 8'(n);
    exp_f_q.push_back({(n > W), bits, data});
  endtask

  // Driver: frame of n bits, MSB first. together puts bit 1 on the opening
  // edge; fall_clk adds a dly_clk rise on the closing edge that must be lost.
  task automatic send_frame(input logic [31:0] val, input int n, input bit together,
                            input bit fall_clk);
    bit sent_q[$];
    bit b;
    int i0;
    i0 = 0;
    @(negedge clk);
    dly_cs = 1'b1;
    if (together && n > 0) begin
      b = (n <= 32) ? val[n-1] : 1'(($urandom) & 1);
      dly_data = b;
      dly_clk  = 1'b1;
      sent_q.push_back(b);
      @(negedge clk);
      dly_clk = 1'b0;
      i0 = 1;
    end
    for (int i = i0; i < n; i++) begin
      b = (n <= 32) ? val[n-1-i] : 1'(($urandom) & 1);
      @(negedge clk);
      dly_data = b;
      dly_clk  = 1'b1;
      sent_q.push_back(b);
      @(negedge clk);
      dly_clk = 1'b0;
    end
    @(negedge clk);
    dly_cs = 1'b0;
    if (fall_clk) begin
      dly_data = 1'b1;
      dly_clk  = 1'b1;
      @(negedge clk);
      dly_clk = 1'b0;
    end
    expect_frame(sent_q);
  endtask

  // Driver: 1-cycle ref_cs pulse, dly_cs rises gap edges later (1-cycle high)
  task automatic do_meas(input int gap);
    bit empty_q[$];
    @(negedge clk);
    ref_cs = 1'b1;
    if (gap == 0) dly_cs = 1'b1;
    @(negedge clk);
    ref_cs = 1'b0;
    if (gap > 0) begin
      repeat (gap - 1) @(negedge clk);
      dly_cs = 1'b1;
      @(negedge clk);
    end
    dly_cs = 1'b0;
    if (gap >= 255) exp_m_q.push_back({1'b1, 8'd255});
    else            exp_m_q.push_back({1'b0, 8'(gap)});
    expect_frame(empty_q);
  endtask

  initial begin
    logic [31:0] rv;
    int          rn;

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    do_meas(0);   check_queues("meas_0");
    do_meas(5);   check_queues("meas_5");
    do_meas(15);  check_queues("meas_15");
    do_meas(1);   check_queues("meas_1");
    do_meas(254); check_queues("meas_254");

    send_frame(32'hA5C3, 16, 1'b0, 1'b0);  check_queues("frame_16");
    send_frame(32'hFA5C3, 20, 1'b0, 1'b0); check_queues("frame_20");
    send_frame(32'h0, 0, 1'b0, 1'b0);      check_queues("frame_0");
    send_frame(32'h1234, 16, 1'b1, 1'b0);  check_queues("frame_together");
    send_frame(32'h5, 3, 1'b0, 1'b1);      check_queues("frame_fall_clk");

    send_frame(32'h3C, 8, 1'b0, 1'b0);
    send_frame(32'h1F0F, 13, 1'b0, 1'b0);
    check_queues("back_to_back");

    send_frame(32'h0, 300, 1'b0, 1'b0);    check_queues("frame_sat");

    // Timeout: the late dly_cs rise arrives with the delay FSM idle
    do_meas(300); check_queues("timeout");

    // Reset mid-frame and mid-measurement
    @(negedge clk);
    dly_cs = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      dly_data = 1'(i & 1);
      dly_clk  = 1'b1;
      @(negedge clk);
      dly_clk = 1'b0;
    end
    ref_cs = 1'b1;
    @(negedge clk);
    ref_cs = 1'b0;
    repeat (2) @(negedge clk);
    rst    = 1'b1;
    dly_cs = 1'b0;
    @(negedge clk);
    check_outputs_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    check_queues("after_reset");
    send_frame(32'hBEEF, 16, 1'b0, 1'b0); check_queues("post_reset_frame");
    do_meas(9);                            check_queues("post_reset_meas");

    for (int t = 0; t < 12; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        rn = $urandom_range(0, 24);
        rv = $urandom;
        send_frame(rv, rn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check_queues("rand_frame");
      end else begin
        do_meas($urandom_range(0, 60));
        check_queues("rand_meas");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_delay_capture.md
# spi_delay_capture

Downstream companion to the switch-selectable variable-delay stage. It consumes the delayed chip-select, serial clock and data that stage produces, deserializes each framed word, and measures the delay in clock cycles between the undelayed and delayed chip-select rising edges. Its outputs let on-board logic and benches confirm the selected delay length without a scope.

## Interface
- W, 16, frame shift-register width in bits (data is MSB first)
- CNT_W, 8, width of the delay counter and the bit counter

- clk  input  1  system clock; all inputs are synchronous to it
- rst  input  1  asynchronous, active-high reset
- ref_cs  input  1  undelayed chip-select, i.e. the delay stage's input
- dly_cs  input  1  delayed chip-select from the delay stage; high means a frame is active
- dly_clk  input  1  serial clock forwarded by the delay stage
- dly_data  input  1  serial data (miso) from the delay stage
- frame_data  output  W  last captured word, right-aligned
- frame_bits  output  CNT_W  number of bits in the last frame, saturating
- frame_ovf  output  1  last frame had more than W bits
- frame_valid  output  1  one-cycle pulse when frame_data, frame_bits and frame_ovf update
- meas_delay  output  CNT_W  last measured delay in clk cycles
- meas_timeout  output  1  last measurement timed out
- meas_valid  output  1  one-cycle pulse when meas_delay and meas_timeout update

## Operation
- Edge detection
  - ref_cs, dly_cs and dly_clk are each registered once and compared with their current sampled value.
  - A rise is current=1 and previous=0; a fall is current=0 and previous=1.
  - No synchronizers: all inputs share the clk domain.
- Frame FSM: two states, IDLE and ACTIVE.
  - IDLE -> ACTIVE on a dly_cs rise. At that edge the shift register and bit counter clear.
  - In ACTIVE, each dly_clk rise shifts dly_data into bit 0; the older bits move toward the MSB.
  - The bit counter increments on each dly_clk rise and saturates at 2^CNT_W-1.
  - ACTIVE -> IDLE on a dly_cs fall. At that edge the block loads frame_data, frame_bits and frame_ovf, and pulses frame_valid.
  - frame_ovf = 1 when the bit count > W. frame_data then holds the last W bits received.
  - A frame with zero dly_clk rises still completes: frame_data=0, frame_bits=0, frame_valid pulses.
- Delay FSM: two states, IDLE and MEAS.
  - IDLE -> MEAS on a ref_cs rise; the counter starts.
  - MEAS -> IDLE on a dly_cs rise: meas_delay = number of clk edges between the two sampled rises, meas_timeout=0, meas_valid pulses.
  - ref_cs and dly_cs rising on the same edge: meas_delay=0 and meas_valid pulses on that edge. This is the zero-length delay case.
  - ref_cs rises while in MEAS are ignored; the pending measurement continues.
  - dly_cs rises while in IDLE (without a simultaneous ref_cs rise) are ignored; no meas_valid.
  - When the count reaches 2^CNT_W-1 without a dly_cs rise: meas_delay=all ones, meas_timeout=1, meas_valid pulses, return to IDLE.
- The frame FSM and the delay FSM are independent and may be active at the same time.

## Timing
- Reset: every output is 0 and both FSMs are in IDLE. The edge-detect registers reset to 0.
  - An input that is already high when reset releases therefore registers as a rise on the first edge after release.
- Reset mid-frame or mid-measurement discards all partial state; no valid pulse follows.
- All outputs are registered.
  - frame_valid is high during the cycle after the clk edge that samples the dly_cs fall.
  - meas_valid follows the same rule relative to the dly_cs rise or the timeout edge.
- Simultaneous events:
  - dly_cs rise together with a dly_clk rise: the bit is captured as bit 1 of the frame.
  - dly_cs fall together with a dly_clk rise: the bit is not captured.
  - dly_cs fall and a new dly_cs rise cannot share an edge, because a single input cannot fall and rise on the same edge.
- Minimum spacing: a frame may start on the edge after frame_valid. Back-to-back frames separated by one low cycle of dly_cs are both captured.
- Latency from a dly_clk rise to the captured bit: 1 cycle (internal). Latency from the dly_cs fall to frame_valid: 1 cycle.

## Test plan
- ref_cs and dly_cs rise on the same edge -> meas_valid once, meas_delay=0, meas_timeout=0.
- ref_cs rises, dly_cs rises 5 edges later, with a 1-cycle pulse -> meas_delay=5. Repeat with 15 -> meas_delay=15.
- dly_cs high, 16 dly_clk pulses carrying 0xA5C3 MSB first, dly_cs low -> frame_valid once, frame_data=0xA5C3, frame_bits=16, frame_ovf=0.
- A 20-bit frame 0xFA5C3 -> frame_data=0xA5C3, frame_bits=20, frame_ovf=1. A zero-clock frame -> frame_bits=0, frame_data=0.
- ref_cs rises with dly_cs held low for 300 cycles -> meas_valid at count 255, meas_delay=255, meas_timeout=1. A later dly_cs rise produces no meas_valid.
- Assert rst after 7 bits of a frame and 3 cycles into a measurement -> all outputs 0 and no valid pulses; the next full frame and measurement then report correctly.
